// File: rtl/snap_capture_ctrl.sv
// rtl/snap_capture_ctrl.sv - snapshot BRAM write-side capture controller
module snap_capture_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ctrl,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  trig,
  output logic                  bram_we,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [31:0]           status
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Counter is one bit wider than the address so a full capture reads 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ctrl0_q;
  logic                arm_ev, qv, tev, wr;

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[31:3];

  assign arm_ev = ctrl[0] & ~ctrl0_q;
  assign qv     = din_valid | ctrl[2];
  assign tev    = ctrl[1] | trig;

  assign status = {done_q, busy_q, {(29-ADDR_WIDTH){1'b0}}, cnt_q};

  // Next-state decode: arm event restarts from any state and suppresses the write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    wr      = 1'b0;
    if (arm_ev) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (tev) begin
            state_d = ST_CAPTURE;
            wr      = qv;
          end
        end
        ST_CAPTURE: wr = qv;
        ST_IDLE, ST_DONE: wr = 1'b0;
        default: state_d = ST_IDLE;
      endcase
      if (wr) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
    end
  end

  // State, counter and registered BRAM port-A write, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ctrl0_q      <= 1'b0;
      bram_we      <= 1'b0;
      bram_en_a    <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ctrl0_q   <= ctrl[0];
      bram_we   <= wr;
      bram_en_a <= wr;
      if (wr) begin
        bram_addr    <= cnt_q[ADDR_WIDTH-1:0];
        bram_wr_data <= din;
      end
    end
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb/tb_snap_capture_ctrl.sv - scoreboard bench for snap_capture_ctrl
module tb_snap_capture_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   ctrl = '0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          trig = 1'b0;
  logic          bram_we, bram_en_a;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  logic [31:0]   status;

  snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .din(din), .din_valid(din_valid),
    .trig(trig), .bram_we(bram_we), .bram_en_a(bram_en_a),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   stat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: capture phase (0 idle, 1 waiting for trigger, 2 capturing, 3 done)
  int            m_phase = 0;
  int            m_words = 0;
  logic          m_prev_arm = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] c, input logic [DW-1:0] d,
                                 input logic v, input logic t, input logic r);
    exp_t e;
    logic arm;
    e.we = 1'b0;
    if (r) begin
      m_phase = 0; m_words = 0; m_prev_arm = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      arm = c[0] && !m_prev_arm;
      m_prev_arm = c[0];
      if (arm) begin
        m_phase = 1;
        m_words = 0;
      end else begin
        if (m_phase == 1 && (c[1] || t)) m_phase = 2;
        if (m_phase == 2 && (v || c[2])) begin
          e.we = 1'b1;
          m_addr = m_words[AW-1:0];
          m_data = d;
          m_words++;
          if (m_words == DEPTH) m_phase = 3;
        end
      end
    end
    e.addr = m_addr;
    e.data = m_data;
    e.stat = (m_phase == 3 ? 32'h8000_0000 : 32'h0) |
             ((m_phase == 1 || m_phase == 2) ? 32'h4000_0000 : 32'h0) | 32'(m_words);
    return e;
  endfunction

  task automatic step(input logic [31:0] c, input logic [DW-1:0] d,
                      input logic v, input logic t, input logic r);
    exp_t e;
    ctrl = c; din = d; din_valid = v; trig = t; rst = r;
    e = model(c, d, v, t, r);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bram_we", DW'(bram_we), DW'(e.we));
      check("bram_en_a", DW'(bram_en_a), DW'(e.we));
      check("bram_addr", DW'(bram_addr), DW'(e.addr));
      check("bram_wr_data", bram_wr_data, e.data);
      check("status", DW'(status), DW'(e.stat));
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [31:0] c;
    // Reset state
    repeat (3) step(32'h0, '0, 1'b0, 1'b0, 1'b1);
    step(32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Immediate trigger, always valid: 16 words with data 1..16, then hold done
    for (int i = 0; i < 24; i++) step(32'h7, DW'(i), 1'b0, 1'b0, 1'b0);
    step(32'h0, '0, 1'b0, 1'b0, 1'b0);

    // Arm pulse, wait on external trigger for 20 cycles, then 0xAB
    step(32'h1, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(32'h0, rnd_data(), 1'b1, 1'b0, 1'b0);
    step(32'h0, DW'(8'hAB), 1'b1, 1'b1, 1'b0);
    // Valid toggling during capture
    for (int i = 0; i < 8; i++) step(32'h0, rnd_data(), 1'(i % 2), 1'b0, 1'b0);
    // Re-arm after 5 words, with a valid sample in the abort cycle
    step(32'h1, rnd_data(), 1'b1, 1'b0, 1'b0);
    step(32'h1, rnd_data(), 1'b1, 1'b1, 1'b0);
    // Capture to done with ctrl[0] held high; no re-arm until it drops
    for (int i = 0; i < 22; i++) step(32'h1, rnd_data(), 1'b1, 1'b1, 1'b0);
    step(32'h0, rnd_data(), 1'b1, 1'b1, 1'b0);
    step(32'h1, rnd_data(), 1'b0, 1'b0, 1'b0);
    // Capture 7 words then reset mid-capture
    for (int i = 0; i < 7; i++) step(32'h1, rnd_data(), 1'b1, 1'b1, 1'b0);
    step(32'h1, rnd_data(), 1'b1, 1'b1, 1'b1);
    // Trigger without arm causes no writes
    for (int i = 0; i < 5; i++) step(32'h0, rnd_data(), 1'b1, 1'b1, 1'b0);

    // Randomized traffic
    c = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      c[31:3] = 29'($urandom);
      if ($urandom_range(0, 29) == 0) c[0] = ~c[0];
      c[1] = ($urandom_range(0, 7) == 0);
      c[2] = ($urandom_range(0, 1) == 0);
      step(c, rnd_data(), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 499) == 0));
    end

    step(32'h0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
